// File: rtl/bch_chien_serial_if.sv
// rtl/bch_chien_serial_if.sv - BCH parameter package and Chien search port bundle
package bch_chien_pkg;
    // P packs {M[7:0], T[7:0], N[15:0]}
    localparam logic [31:0] BCH_SANE = {8'd4, 8'd2, 16'd15};

    function automatic int bch_m(input logic [31:0] p);
        return int'(p[31:24]);
    endfunction

    function automatic int bch_t(input logic [31:0] p);
        return int'(p[23:16]);
    endfunction

    function automatic int bch_n(input logic [31:0] p);
        return int'(p[15:0]);
    endfunction

    function automatic int bch_sigma_sz(input logic [31:0] p);
        return (bch_t(p) + 1) * bch_m(p);
    endfunction

    // Wide enough to hold T+1 so an over-degree err_count is representable
    function automatic int bch_err_sz(input logic [31:0] p);
        return $clog2(bch_t(p) + 2);
    endfunction

    function automatic logic [16:0] bch_prim(input int m);
        case (m)
            3:       return 17'h0000B;
            5:       return 17'h00025;
            6:       return 17'h00043;
            7:       return 17'h00089;
            8:       return 17'h0011D;
            9:       return 17'h00211;
            10:      return 17'h00409;
            11:      return 17'h00805;
            12:      return 17'h01053;
            13:      return 17'h0201B;
            14:      return 17'h04443;
            15:      return 17'h08003;
            16:      return 17'h1100B;
            default: return 17'h00013;
        endcase
    endfunction
endpackage

interface bch_chien_serial_if #(
    parameter logic [31:0] P = bch_chien_pkg::BCH_SANE
);
    localparam int SIGMA_SZ = bch_chien_pkg::bch_sigma_sz(P);
    localparam int ERR_SZ   = bch_chien_pkg::bch_err_sz(P);

    logic                sigma_valid;
    logic                sigma_accepted;
    logic [SIGMA_SZ-1:0] sigma;
    logic [ERR_SZ-1:0]   err_count;
    logic                ce;
    logic                busy;
    logic                err_valid;
    logic                err;
    logic                err_first;
    logic                err_last;
    logic [ERR_SZ-1:0]   root_count;
    logic                fail;

    modport slave (
        input  sigma_valid, sigma, err_count, ce,
        output sigma_accepted, busy, err_valid, err, err_first, err_last, root_count, fail
    );

    modport master (
        output sigma_valid, sigma, err_count, ce,
        input  sigma_accepted, busy, err_valid, err, err_first, err_last, root_count, fail
    );
endinterface

// File: rtl/bch_chien_serial.sv
// rtl/bch_chien_serial.sv - serial Chien search emitting one error flag per codeword position
module bch_chien_serial
    import bch_chien_pkg::*;
#(
    parameter logic [31:0] P = BCH_SANE
) (
    input  logic              clk,
    input  logic              reset_n,
    bch_chien_serial_if.slave bus
);
    localparam int          M    = bch_m(P);
    localparam int          T    = bch_t(P);
    localparam int          N    = bch_n(P);
    localparam int          ESZ  = bch_err_sz(P);
    localparam int          KW   = $clog2(N);
    localparam logic [16:0] PRIM = bch_prim(M);

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = sh[M-1] ? ((sh << 1) ^ PRIM[M-1:0]) : (sh << 1);
        end
        return acc;
    endfunction

    function automatic logic [M-1:0] gf_alpha_pow(input int e);
        logic [M-1:0] r;
        r = M'(1);
        for (int i = 0; i < e % ((1 << M) - 1); i++) r = gf_mul(r, M'(2));
        return r;
    endfunction

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t         r_state, w_state_next;
    logic [M-1:0]   r_s0;
    logic [M-1:0]   r_term [1:T];
    logic [M-1:0]   w_load [1:T];
    logic [M-1:0]   w_step [1:T];
    logic [M-1:0]   w_sum;
    logic [ESZ-1:0] r_errc, r_cnt, w_cnt_next, r_root_count;
    logic [KW-1:0]  r_k;
    logic           w_accept, w_root, w_last, w_fail;
    logic           r_err_valid, r_err, r_err_first, r_err_last, r_fail;

    // Preload shifts each term so stream index 0 evaluates at alpha^-(N-1) for shortened codes
    genvar gj;
    for (gj = 1; gj <= T; gj++) begin : g_term
        localparam logic [M-1:0] LOAD_C = gf_alpha_pow(gj * ((1 << M) - N));
        localparam logic [M-1:0] STEP_C = gf_alpha_pow(gj);
        assign w_load[gj] = gf_mul(bus.sigma[gj*M +: M], LOAD_C);
        assign w_step[gj] = gf_mul(r_term[gj], STEP_C);
    end

    always_comb begin
        w_sum = r_s0;
        for (int j = 1; j <= T; j++) w_sum = w_sum ^ r_term[j];
    end

    assign w_root     = (w_sum == '0);
    assign w_last     = (r_k == KW'(N - 1));
    assign w_cnt_next = (w_root && (r_cnt != '1)) ? r_cnt + ESZ'(1) : r_cnt;
    assign w_fail     = (w_cnt_next != r_errc) || (r_errc > ESZ'(T));
    assign w_accept   = bus.sigma_valid && (r_state == S_IDLE) && reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_RUN;
            S_RUN:   if (bus.ce && w_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s0         <= '0;
            for (int j = 1; j <= T; j++) r_term[j] <= '0;
            r_errc       <= '0;
            r_cnt        <= '0;
            r_root_count <= '0;
            r_k          <= '0;
            r_fail       <= 1'b0;
            r_err_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_err_first  <= 1'b0;
            r_err_last   <= 1'b0;
        end else begin
            r_err_valid <= 1'b0;
            r_err       <= 1'b0;
            r_err_first <= 1'b0;
            r_err_last  <= 1'b0;
            if (w_accept) begin
                r_s0         <= bus.sigma[M-1:0];
                for (int j = 1; j <= T; j++) r_term[j] <= w_load[j];
                r_errc       <= bus.err_count;
                r_k          <= '0;
                r_cnt        <= '0;
                r_root_count <= '0;
                r_fail       <= 1'b0;
            end else if ((r_state == S_RUN) && bus.ce) begin
                r_err_valid <= 1'b1;
                r_err       <= w_root;
                r_err_first <= (r_k == '0);
                r_err_last  <= w_last;
                for (int j = 1; j <= T; j++) r_term[j] <= w_step[j];
                r_k         <= r_k + KW'(1);
                r_cnt       <= w_cnt_next;
                if (w_last) begin
                    r_root_count <= w_cnt_next;
                    r_fail       <= w_fail;
                end
            end
        end
    end

    assign bus.sigma_accepted = w_accept;
    assign bus.busy           = (r_state == S_RUN);
    assign bus.err_valid      = r_err_valid;
    assign bus.err            = r_err;
    assign bus.err_first      = r_err_first;
    assign bus.err_last       = r_err_last;
    assign bus.root_count     = r_root_count;
    assign bus.fail           = r_fail;
endmodule

// File: tb/tb_bch_chien_serial.sv
// tb/tb_bch_chien_serial.sv - scoreboard bench for the serial Chien search (M=4, T=2, N=15)
module tb_bch_chien_serial;
    import bch_chien_pkg::*;

    localparam int NN = 15;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [2:0] exp_q[$];
    logic [2:0] obs_q[$];
    logic [1:0] exp_rc[$];
    logic       exp_fl[$];
    int         obs_cyc[$];
    int         obs_acc[$];
    logic [1:0] obs_rc;
    logic       obs_fail;

    bch_chien_serial_if bus ();

    bch_chien_serial dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] pack(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2);
        return {s2, s1, s0};
    endfunction

    // Expected triple per stream index k: {err, err_first, err_last}; position = N-1-k
    task automatic push_expected(input int p0, input int p1, input logic [1:0] rc, input logic fl);
        exp_q.delete();
        exp_rc.delete();
        exp_fl.delete();
        for (int k = 0; k < NN; k++)
            exp_q.push_back({((NN - 1 - k) == p0) || ((NN - 1 - k) == p1), k == 0, k == NN - 1});
        exp_rc.push_back(rc);
        exp_fl.push_back(fl);
    endtask

    task automatic do_accept(input logic [11:0] s, input logic [1:0] ec, input bit hold, output int a);
        bus.sigma       = s;
        bus.err_count   = ec;
        bus.sigma_valid = 1'b1;
        a = -1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bus.sigma_accepted === 1'b1) begin
                a = cyc;
                break;
            end
            @(negedge clk);
        end
        if (a < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout got no sigma_accepted want a pulse within 40 cycles");
        end
        @(negedge clk);
        if (!hold) bus.sigma_valid = 1'b0;
    endtask

    task automatic capture(input int stall_at, input int stall_len, input int abort_at);
        int stall_left;
        bit stalled;
        stall_left = 0;
        stalled    = 1'b0;
        obs_q.delete();
        obs_cyc.delete();
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.sigma_accepted === 1'b1) obs_acc.push_back(cyc);
            if (bus.err_valid === 1'b1) begin
                obs_q.push_back({bus.err, bus.err_first, bus.err_last});
                obs_cyc.push_back(cyc);
                if (bus.err_last === 1'b1) begin
                    obs_rc   = bus.root_count;
                    obs_fail = bus.fail;
                    bus.ce   = 1'b1;
                    return;
                end
            end
            if (abort_at >= 0 && obs_q.size() == abort_at) return;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) bus.ce = 1'b1;
            end else if (!stalled && obs_q.size() == stall_at) begin
                stalled    = 1'b1;
                bus.ce     = 1'b0;
                stall_left = stall_len;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL capture_timeout got %0d bits want a complete stream", obs_q.size());
    endtask

    task automatic test_reset();
        bus.sigma       = pack(4'h1, 4'hF, 4'hD);
        bus.err_count   = 2'd2;
        bus.sigma_valid = 1'b1;
        bus.ce          = 1'b1;
        reset_n         = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if ({bus.sigma_accepted, bus.busy, bus.err_valid, bus.err, bus.err_first, bus.err_last,
             bus.fail, bus.root_count} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b want 0", {bus.sigma_accepted, bus.busy, bus.err_valid,
                     bus.err, bus.err_first, bus.err_last, bus.fail, bus.root_count});
        end
        bus.sigma_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        n_tests++;
        if ({bus.busy, bus.sigma_accepted, bus.err_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle got %b want 000", {bus.busy, bus.sigma_accepted, bus.err_valid});
        end
    endtask

    task automatic test_two_errors();
        int a;
        logic [2:0] e, o;
        do_accept(pack(4'h1, 4'hF, 4'hD), 2'd2, 1'b0, a);
        push_expected(10, 3, 2'd2, 1'b0);
        capture(-1, 0, -1);
        n_tests++;
        if (obs_q.size() != NN) begin n_fail++; $display("FAIL two_err_count got %0d want %0d", obs_q.size(), NN); end
        for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL two_err_bit k=%0d got %b want %b", k, o, e); end
        end
        n_tests++;
        if (obs_rc !== exp_rc.pop_front()) begin n_fail++; $display("FAIL two_err_roots got %0d want 2", obs_rc); end
        n_tests++;
        if (obs_fail !== exp_fl.pop_front()) begin n_fail++; $display("FAIL two_err_fail got %b want 0", obs_fail); end
        n_tests++;
        if (obs_cyc.size() != NN || obs_cyc[0] != a + 2 || obs_cyc[NN-1] != a + 16) begin
            n_fail++;
            $display("FAIL two_err_timing got first/last %0d/%0d want %0d/%0d", obs_cyc.size() > 0 ? obs_cyc[0] : -1,
                     obs_cyc.size() > 0 ? obs_cyc[obs_cyc.size()-1] : -1, a + 2, a + 16);
        end
    endtask

    task automatic test_pos0();
        int a;
        logic [2:0] e, o;
        do_accept(pack(4'h1, 4'h1, 4'h0), 2'd1, 1'b0, a);
        push_expected(0, -1, 2'd1, 1'b0);
        capture(-1, 0, -1);
        n_tests++;
        if (obs_q.size() != NN) begin n_fail++; $display("FAIL pos0_count got %0d want %0d", obs_q.size(), NN); end
        for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL pos0_bit k=%0d got %b want %b", k, o, e); end
        end
        n_tests++;
        if ({obs_rc, obs_fail} !== {exp_rc.pop_front(), exp_fl.pop_front()}) begin
            n_fail++;
            $display("FAIL pos0_result got rc=%0d fail=%b want rc=1 fail=0", obs_rc, obs_fail);
        end
    endtask

    task automatic test_no_errors();
        int a;
        logic [2:0] e, o;
        do_accept(pack(4'h1, 4'h0, 4'h0), 2'd0, 1'b0, a);
        push_expected(-1, -1, 2'd0, 1'b0);
        capture(-1, 0, -1);
        n_tests++;
        if (obs_q.size() != NN) begin n_fail++; $display("FAIL noerr_count got %0d want %0d", obs_q.size(), NN); end
        for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL noerr_bit k=%0d got %b want %b", k, o, e); end
        end
        n_tests++;
        if ({obs_rc, obs_fail} !== {exp_rc.pop_front(), exp_fl.pop_front()}) begin
            n_fail++;
            $display("FAIL noerr_result got rc=%0d fail=%b want rc=0 fail=0", obs_rc, obs_fail);
        end
    endtask

    task automatic test_mismatch();
        int a;
        logic [2:0] e, o;
        do_accept(pack(4'h1, 4'h1, 4'h0), 2'd2, 1'b0, a);
        push_expected(0, -1, 2'd1, 1'b1);
        capture(-1, 0, -1);
        for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL mismatch_bit k=%0d got %b want %b", k, o, e); end
        end
        n_tests++;
        if ({obs_rc, obs_fail} !== {exp_rc.pop_front(), exp_fl.pop_front()}) begin
            n_fail++;
            $display("FAIL mismatch_result got rc=%0d fail=%b want rc=1 fail=1", obs_rc, obs_fail);
        end
    endtask

    task automatic test_back_to_back();
        int a, hits, bad;
        logic [2:0] e, o;
        obs_acc.delete();
        do_accept(pack(4'h1, 4'hF, 4'hD), 2'd2, 1'b1, a);
        for (int s = 0; s < 2; s++) begin
            push_expected(10, 3, 2'd2, 1'b0);
            capture(-1, 0, -1);
            for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                n_tests++;
                if (o !== e) begin n_fail++; $display("FAIL b2b_bit s=%0d k=%0d got %b want %b", s, k, o, e); end
            end
            n_tests++;
            if ({obs_rc, obs_fail} !== {exp_rc.pop_front(), exp_fl.pop_front()}) begin
                n_fail++;
                $display("FAIL b2b_result s=%0d got rc=%0d fail=%b want rc=2 fail=0", s, obs_rc, obs_fail);
            end
        end
        bus.sigma_valid = 1'b0;
        n_tests++;
        if (obs_cyc.size() == 0 || obs_cyc[0] != a + 18) begin
            n_fail++;
            $display("FAIL b2b_first got %0d want %0d", obs_cyc.size() > 0 ? obs_cyc[0] : -1, a + 18);
        end
        hits = 0;
        bad  = 0;
        foreach (obs_acc[i]) begin
            if (obs_acc[i] < a + 32) begin
                hits++;
                if (obs_acc[i] != a + 16) bad++;
            end
        end
        n_tests++;
        if (hits != 1 || bad != 0) begin
            n_fail++;
            $display("FAIL b2b_accept got %0d pulses (%0d misplaced) want 1 at %0d", hits, bad, a + 16);
        end
    endtask

    task automatic test_ce_stall();
        int a;
        logic [2:0] e, o;
        do_accept(pack(4'h1, 4'hF, 4'hD), 2'd2, 1'b0, a);
        push_expected(10, 3, 2'd2, 1'b0);
        capture(4, 3, -1);
        n_tests++;
        if (obs_q.size() != NN) begin n_fail++; $display("FAIL stall_count got %0d want %0d", obs_q.size(), NN); end
        for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL stall_bit k=%0d got %b want %b", k, o, e); end
        end
        n_tests++;
        if ({obs_rc, obs_fail} !== {exp_rc.pop_front(), exp_fl.pop_front()}) begin
            n_fail++;
            $display("FAIL stall_result got rc=%0d fail=%b want rc=2 fail=0", obs_rc, obs_fail);
        end
        n_tests++;
        if (obs_cyc.size() != NN || obs_cyc[0] != a + 2 || obs_cyc[4] != a + 9 || obs_cyc[NN-1] != a + 19) begin
            n_fail++;
            $display("FAIL stall_timing got last %0d want %0d", obs_cyc.size() > 0 ? obs_cyc[obs_cyc.size()-1] : -1, a + 19);
        end
    endtask

    task automatic test_reset_mid_stream();
        int a, rel;
        logic [2:0] e, o;
        do_accept(pack(4'h1, 4'hF, 4'hD), 2'd2, 1'b1, a);
        capture(-1, 0, 8);
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.sigma_accepted, bus.busy, bus.err_valid, bus.err, bus.err_first, bus.err_last,
             bus.fail, bus.root_count} !== 9'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs got %b want 0", {bus.sigma_accepted, bus.busy, bus.err_valid,
                     bus.err, bus.err_first, bus.err_last, bus.fail, bus.root_count});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rel = cyc;
        do_accept(pack(4'h1, 4'hF, 4'hD), 2'd2, 1'b0, a);
        n_tests++;
        if (a != rel) begin n_fail++; $display("FAIL midreset_accept got cycle %0d want %0d", a, rel); end
        push_expected(10, 3, 2'd2, 1'b0);
        capture(-1, 0, -1);
        n_tests++;
        if (obs_q.size() != NN) begin n_fail++; $display("FAIL midreset_count got %0d want %0d", obs_q.size(), NN); end
        for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL midreset_bit k=%0d got %b want %b", k, o, e); end
        end
        n_tests++;
        if ({obs_rc, obs_fail} !== {exp_rc.pop_front(), exp_fl.pop_front()}) begin
            n_fail++;
            $display("FAIL midreset_result got rc=%0d fail=%b want rc=2 fail=0", obs_rc, obs_fail);
        end
    endtask

    initial begin
        bus.sigma_valid = 1'b0;
        bus.sigma       = '0;
        bus.err_count   = '0;
        bus.ce          = 1'b1;
        test_reset();
        test_two_errors();
        test_pos0();
        test_no_errors();
        test_mismatch();
        test_back_to_back();
        test_ce_stall();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
